// File: rtl/icetap_pkg.sv
// Shared icetap JTAG constants: instruction codes, TAP state encodings and the
// strobe bundle passed from the TAP state machine to the instruction/data logic.
package icetap_pkg;

  localparam int IR_BITS_DEFAULT = 4;

  localparam logic [3:0] JTAG_IR_EXTEST = 4'h0;
  localparam logic [3:0] JTAG_IR_IDCODE = 4'h1;
  localparam logic [3:0] JTAG_IR_SCAN_N = 4'h2;
  localparam logic [3:0] JTAG_IR_BYPASS = 4'hF;

  // Classic 1149.1 state encoding as used by most reference TAPs
  localparam logic [3:0] TAP_EXIT2_DR   = 4'h0;
  localparam logic [3:0] TAP_EXIT1_DR   = 4'h1;
  localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
  localparam logic [3:0] TAP_PAUSE_DR   = 4'h3;
  localparam logic [3:0] TAP_SEL_IR     = 4'h4;
  localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
  localparam logic [3:0] TAP_CAPTURE_DR = 4'h6;
  localparam logic [3:0] TAP_SEL_DR     = 4'h7;
  localparam logic [3:0] TAP_EXIT2_IR   = 4'h8;
  localparam logic [3:0] TAP_EXIT1_IR   = 4'h9;
  localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
  localparam logic [3:0] TAP_PAUSE_IR   = 4'hB;
  localparam logic [3:0] TAP_RUN_IDLE   = 4'hC;
  localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;
  localparam logic [3:0] TAP_CAPTURE_IR = 4'hE;
  localparam logic [3:0] TAP_TLR        = 4'hF;

  typedef struct packed {
    logic test_logic_reset;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_strobes_t;

endpackage

// File: rtl/icetap_tap_fsm.sv
// TAP state register and next-state logic; strobes decode the registered state
// only, so they never glitch with tms.
module icetap_tap_fsm
  import icetap_pkg::*;
(
  input  logic         tck,
  input  logic         reset,
  input  logic         tms,
  output tap_strobes_t strb
);

  logic [3:0] state;
  logic [3:0] state_next;

  always_comb begin
    state_next = TAP_TLR;
    case (state)
      TAP_TLR:        state_next = tms ? TAP_TLR      : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   state_next = tms ? TAP_SEL_DR   : TAP_RUN_IDLE;
      TAP_SEL_DR:     state_next = tms ? TAP_SEL_IR   : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   state_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   state_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   state_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  state_next = tms ? TAP_SEL_DR   : TAP_RUN_IDLE;
      TAP_SEL_IR:     state_next = tms ? TAP_TLR      : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   state_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   state_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   state_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  state_next = tms ? TAP_SEL_DR   : TAP_RUN_IDLE;
      default:        state_next = TAP_TLR;
    endcase
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) state <= TAP_TLR;
    else       state <= state_next;
  end

  always_comb begin
    strb.test_logic_reset = (state == TAP_TLR);
    strb.capture_dr       = (state == TAP_CAPTURE_DR);
    strb.shift_dr         = (state == TAP_SHIFT_DR);
    strb.update_dr        = (state == TAP_UPDATE_DR);
    strb.capture_ir       = (state == TAP_CAPTURE_IR);
    strb.shift_ir         = (state == TAP_SHIFT_IR);
    strb.update_ir        = (state == TAP_UPDATE_IR);
  end

endmodule

// File: rtl/icetap_jtag_tap.sv
// JTAG TAP: instruction register, IDCODE and BYPASS data registers, and the
// negedge-registered TDO mux that also forwards the icetap register-block TDO.
module icetap_jtag_tap
  import icetap_pkg::*;
#(
  parameter int          IR_BITS = IR_BITS_DEFAULT,
  parameter logic [31:0] IDCODE  = 32'h1CE7_A001
) (
  input  logic tck,
  input  logic reset,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_ena,
  input  logic regs_tdo,
  output logic test_logic_reset,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir,
  output logic scan_n_ir,
  output logic extest_ir,
  output logic idcode_ir,
  output logic bypass_ir
);

  localparam logic [IR_BITS-1:0] IR_EXTEST = IR_BITS'(JTAG_IR_EXTEST);
  localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(JTAG_IR_IDCODE);
  localparam logic [IR_BITS-1:0] IR_SCAN_N = IR_BITS'(JTAG_IR_SCAN_N);
  localparam logic [IR_BITS-1:0] IR_BYPASS = IR_BITS'(JTAG_IR_BYPASS);

  tap_strobes_t        strb;
  logic [IR_BITS-1:0]  ir;
  logic [IR_BITS-1:0]  ir_shift;
  logic [31:0]         idcode_shift;
  logic                bypass_reg;
  logic                tdo_mux;

  icetap_tap_fsm u_fsm (
    .tck   (tck),
    .reset (reset),
    .tms   (tms),
    .strb  (strb)
  );

  assign test_logic_reset = strb.test_logic_reset;
  assign capture_dr       = strb.capture_dr;
  assign shift_dr         = strb.shift_dr;
  assign update_dr        = strb.update_dr;
  assign capture_ir       = strb.capture_ir;
  assign shift_ir         = strb.shift_ir;
  assign update_ir        = strb.update_ir;

  assign scan_n_ir = (ir == IR_SCAN_N);
  assign extest_ir = (ir == IR_EXTEST);
  assign idcode_ir = (ir == IR_IDCODE);
  // Any code without a register of its own falls back to the 1-bit bypass path
  assign bypass_ir = (ir == IR_BYPASS) | ~(scan_n_ir | extest_ir | idcode_ir);

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
    end else begin
      if (strb.capture_ir)
        ir_shift <= IR_BITS'(2'b01);
      else if (strb.shift_ir)
        ir_shift <= {tdi, ir_shift[IR_BITS-1:1]};

      if (strb.test_logic_reset)
        ir <= IR_IDCODE;
      else if (strb.update_ir)
        ir <= ir_shift;
    end
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      idcode_shift <= IDCODE;
      bypass_reg   <= 1'b0;
    end else begin
      if (idcode_ir) begin
        if (strb.capture_dr)
          idcode_shift <= IDCODE;
        else if (strb.shift_dr)
          idcode_shift <= {tdi, idcode_shift[31:1]};
      end
      if (bypass_ir) begin
        if (strb.capture_dr)
          bypass_reg <= 1'b0;
        else if (strb.shift_dr)
          bypass_reg <= tdi;
      end
    end
  end

  always_comb begin
    if (strb.shift_ir)
      tdo_mux = ir_shift[0];
    else if (idcode_ir)
      tdo_mux = idcode_shift[0];
    else if (scan_n_ir | extest_ir)
      tdo_mux = regs_tdo;
    else
      tdo_mux = bypass_reg;
  end

  // Falling-edge update gives the far end a full half-cycle of setup before it samples
  always_ff @(negedge tck or posedge reset) begin
    if (reset) begin
      tdo     <= 1'b0;
      tdo_ena <= 1'b0;
    end else begin
      tdo_ena <= strb.shift_ir | strb.shift_dr;
      if (strb.shift_ir | strb.shift_dr)
        tdo <= tdo_mux;
    end
  end

endmodule

// File: tb/tb_icetap_jtag_tap.sv
// Self-checking bench for icetap_jtag_tap: a table of TAP paths, directed
// IR/DR sequences, and a long random walk against a diagram-level TAP model.
module tb_icetap_jtag_tap;

  localparam logic [31:0] ID = 32'h1CE7_A001;

  logic tck, reset, tms, tdi, regs_tdo;
  logic tdo, tdo_ena;
  logic test_logic_reset, capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;
  logic scan_n_ir, extest_ir, idcode_ir, bypass_ir;

  icetap_jtag_tap dut (
    .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_ena(tdo_ena),
    .regs_tdo(regs_tdo), .test_logic_reset(test_logic_reset),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .scan_n_ir(scan_n_ir), .extest_ir(extest_ir), .idcode_ir(idcode_ir),
    .bypass_ir(bypass_ir)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // {tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir} and {scan_n, extest, idcode, bypass}
  wire [6:0] strb = {test_logic_reset, capture_dr, shift_dr, update_dr,
                     capture_ir, shift_ir, update_ir};
  wire [3:0] dec  = {scan_n_ir, extest_ir, idcode_ir, bypass_ir};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Inputs change just after a falling edge; everything is sampled just after the next one.
  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic do_reset();
    @(negedge tck);
    #1;
    tms = 1'b1;
    tdi = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap,
                         output logic [3:0] dec_at_upd);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      tick(i == 3, v[i]);
    end
    tick(1, 0);
    dec_at_upd = dec;
    tick(0, 0);
  endtask

  task automatic goto_shift_dr();
    tick(1, 0); tick(0, 0); tick(0, 0);
  endtask

  task automatic exit_dr();
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] path;
    int          len;
    logic [6:0]  exp_strb;
  } vec_t;

  vec_t vecs[16];

  // Reference TAP diagram, states numbered in walk order TLR=0 .. UPDATE_IR=15
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  bit visited[32];

  function automatic logic [6:0] model_strb(input int s);
    return {s == 0, s == 3, s == 4, s == 8, s == 10, s == 11, s == 15};
  endfunction

  function automatic logic [3:0] model_dec(input logic [3:0] irv);
    logic known;
    known = (irv == 4'h0) || (irv == 4'h1) || (irv == 4'h2);
    return {irv == 4'h2, irv == 4'h0, irv == 4'h1, !known};
  endfunction

  logic [3:0] cap, dupd;
  logic [7:0] pat;
  int mst;
  logic [3:0] m_ir, m_irs;
  logic [31:0] m_ids;
  logic m_byp, m_tdo, m_ena, t, d, r;
  int arcs;

  initial begin
    tms = 1'b1; tdi = 1'b0; regs_tdo = 1'b0; reset = 1'b0;

    vecs[0]  = '{"tlr",      16'b0,         0, 7'b1000000};
    vecs[1]  = '{"run_idle", 16'b0,         1, 7'b0000000};
    vecs[2]  = '{"sel_dr",   16'b10,        2, 7'b0000000};
    vecs[3]  = '{"cap_dr",   16'b010,       3, 7'b0100000};
    vecs[4]  = '{"shift_dr", 16'b0010,      4, 7'b0010000};
    vecs[5]  = '{"exit1_dr", 16'b1010,      4, 7'b0000000};
    vecs[6]  = '{"pause_dr", 16'b01010,     5, 7'b0000000};
    vecs[7]  = '{"exit2_dr", 16'b101010,    6, 7'b0000000};
    vecs[8]  = '{"upd_dr",   16'b11010,     5, 7'b0001000};
    vecs[9]  = '{"sel_ir",   16'b110,       3, 7'b0000000};
    vecs[10] = '{"cap_ir",   16'b0110,      4, 7'b0000100};
    vecs[11] = '{"shift_ir", 16'b00110,     5, 7'b0000010};
    vecs[12] = '{"exit1_ir", 16'b10110,     5, 7'b0000000};
    vecs[13] = '{"pause_ir", 16'b010110,    6, 7'b0000000};
    vecs[14] = '{"exit2_ir", 16'b1010110,   7, 7'b0000000};
    vecs[15] = '{"upd_ir",   16'b110110,    6, 7'b0000001};

    // Reset state
    do_reset();
    chk("rst_strobes", 32'(strb), 32'(7'b1000000));
    chk("rst_decode", 32'(dec), 32'(4'b0010));
    chk("rst_tdo_ena", 32'(tdo_ena), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);

    // Every state from TLR, then five tms=1 edges must land in TLR
    for (int v = 0; v < 16; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].len; i++) tick(vecs[v].path[i], 0);
      chk({"strb_", vecs[v].name}, 32'(strb), 32'(vecs[v].exp_strb));
      chk({"ena_", vecs[v].name}, 32'(tdo_ena), 32'(vecs[v].exp_strb[4] | vecs[v].exp_strb[1]));
      for (int i = 0; i < 5; i++) tick(1, 0);
      chk({"tlr5_", vecs[v].name}, 32'(test_logic_reset), 32'd1);
    end

    // IDCODE read-out, then zeros from tdi
    do_reset();
    tick(0, 0);
    goto_shift_dr();
    for (int i = 0; i < 36; i++) begin
      chk($sformatf("idcode_bit%0d", i), 32'(tdo), (i < 32) ? 32'(ID[i]) : 32'd0);
      chk("idcode_ena", 32'(tdo_ena), 32'd1);
      tick(0, 0);
    end
    tick(1, 0);
    chk("idcode_ena_exit1", 32'(tdo_ena), 32'd0);
    tick(0, 0);
    chk("pause_dr_ena", 32'(tdo_ena), 32'd0);

    // Reset while in SHIFT_DR: abort, no update_dr afterwards
    do_reset();
    tick(0, 0);
    goto_shift_dr();
    tick(0, 1); tick(0, 1);
    tms = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("midrst_tlr", 32'(test_logic_reset), 32'd1);
    chk("midrst_idcode", 32'(idcode_ir), 32'd1);
    chk("midrst_ena", 32'(tdo_ena), 32'd0);
    chk("midrst_tdo", 32'(tdo), 32'd0);
    @(posedge tck);
    #1;
    chk("midrst_held_upd", 32'(update_dr), 32'd0);
    @(negedge tck);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      chk("midrst_no_upd", 32'(strb), 32'd0);
    end

    // IR capture pattern, SCAN_N then EXTEST; regs_tdo forwarded
    do_reset();
    tick(0, 0);
    load_ir(4'h2, cap, dupd);
    chk("ir_capture_bits", 32'(cap), 32'(4'b0001));
    chk("decode_at_upd_ir", 32'(dupd), 32'(4'b0010));
    chk("decode_scan_n", 32'(dec), 32'(4'b1000));
    load_ir(4'h0, cap, dupd);
    chk("decode_extest", 32'(dec), 32'(4'b0100));
    pat = 8'b1011_0010;
    tick(1, 0); tick(0, 0);
    for (int i = 0; i < 8; i++) begin
      regs_tdo = pat[i];
      tick(0, 0);
      chk($sformatf("regs_tdo_%0d", i), 32'(tdo), 32'(pat[i]));
    end
    regs_tdo = 1'b0;
    exit_dr();

    // Reset coinciding with UPDATE_IR wins
    do_reset();
    tick(0, 0);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 0); tick(0, 1); tick(0, 0); tick(1, 0);
    tick(1, 0);
    chk("at_upd_ir", 32'(update_ir), 32'd1);
    tms = 1'b0;
    reset = 1'b1;
    @(posedge tck);
    @(negedge tck);
    #1;
    chk("rst_vs_upd_decode", 32'(dec), 32'(4'b0010));
    reset = 1'b0;
    tick(0, 0);
    chk("rst_vs_upd_after", 32'(dec), 32'(4'b0010));

    // BYPASS and undefined IR codes
    do_reset();
    tick(0, 0);
    load_ir(4'hF, cap, dupd);
    chk("decode_bypass_f", 32'(dec), 32'(4'b0001));
    load_ir(4'h7, cap, dupd);
    chk("decode_bypass_7", 32'(dec), 32'(4'b0001));
    goto_shift_dr();
    chk("bypass_first", 32'(tdo), 32'd0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick(0, pat[i]);
      chk($sformatf("bypass_bit%0d", i), 32'(tdo), 32'(pat[i]));
    end
    exit_dr();

    // Random walk against the reference model
    do_reset();
    mst = 0; m_ir = 4'h1; m_irs = 4'h0; m_ids = ID; m_byp = 1'b0; m_tdo = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      t = ($urandom_range(0, 99) < 45);
      d = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      regs_tdo = r;
      visited[mst * 2 + int'(t)] = 1'b1;
      case (mst)
        10: m_irs = 4'b0001;
        11: m_irs = {d, m_irs[3:1]};
        15: m_ir = m_irs;
        0:  m_ir = 4'h1;
        3: begin
          if (m_ir == 4'h1) m_ids = ID;
          else if (model_dec(m_ir)[0]) m_byp = 1'b0;
        end
        4: begin
          if (m_ir == 4'h1) m_ids = {d, m_ids[31:1]};
          else if (model_dec(m_ir)[0]) m_byp = d;
        end
        default: ;
      endcase
      mst = t ? nxt1[mst] : nxt0[mst];
      tick(t, d);
      m_ena = (mst == 11) || (mst == 4);
      if (mst == 11) m_tdo = m_irs[0];
      else if (mst == 4) begin
        if (m_ir == 4'h1) m_tdo = m_ids[0];
        else if (m_ir == 4'h0 || m_ir == 4'h2) m_tdo = r;
        else m_tdo = m_byp;
      end
      chk("walk_strobes", 32'(strb), 32'(model_strb(mst)));
      chk("walk_decode", 32'(dec), 32'(model_dec(m_ir)));
      chk("walk_tdo_ena", 32'(tdo_ena), 32'(m_ena));
      chk("walk_tdo", 32'(tdo), 32'(m_tdo));
    end
    arcs = 0;
    for (int i = 0; i < 32; i++) if (visited[i]) arcs++;
    chk("walk_arcs_visited", 32'(arcs), 32'd32);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
